// File: rtl/conv_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module : conv_host_pkg
//  Brief  : Shared types and constants for the CONV engine host responder.
//           Word/address widths, bank depths, bank-select codes, FSM state.
//  Rev    : 1.0  initial release
// ============================================================================
package conv_host_pkg;

    localparam int DW         = 20;    // pixel/result word, signed Q4.16 raw
    localparam int AW         = 12;    // image / L0 address width
    localparam int L1_AW      = 10;    // L1 (pooled) address width
    localparam int L0_DEPTH   = 4096;
    localparam int L1_DEPTH   = 1024;
    localparam int DUMP_WORDS = L0_DEPTH + L1_DEPTH;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        DUMP = 3'd3,
        DONE = 3'd4
    } state_t;

    // True when a full-width layer address falls inside the L1 bank.
    function automatic logic l1_addr_ok(input logic [AW-1:0] addr);
        return addr < AW'(L1_DEPTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_host_if.sv
`default_nettype none
// ============================================================================
//  Module : conv_host_if
//  Brief  : Engine <-> host handshake bundle.
//           master : CONV engine (drives busy, addresses, strobes, write data)
//           slave  : host responder (drives ready, idata, cdata_rd)
//  Rev    : 1.0  initial release
// ============================================================================
interface conv_host_if;
    import conv_host_pkg::*;

    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel;

    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

endinterface
`default_nettype wire

// File: rtl/conv_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module : conv_bank_ram
//  Brief  : Word memory, one synchronous write port, one asynchronous read
//           port. Contents are not initialised or cleared.
//  Ports  : clk, we/waddr/wdata (write), raddr/rdata (read)
//  Rev    : 1.0  initial release
// ============================================================================
module conv_bank_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 20
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/conv_host_responder.sv
`default_nettype none
// ============================================================================
//  Module : conv_host_responder
//  Brief  : Host/memory end of the CONV engine. Serves image pixels, answers
//           L0/L1 layer reads and writes, detects end of run on busy falling
//           and streams L0 then L1 out through a valid/ready dump port.
//  Ports  : clk, reset (async, active-high)
//           img_we/img_waddr/img_wdata  image load
//           start                       begin a run
//           eng                         engine handshake bundle (slave side)
//           out_valid/out_ready/out_bank/out_addr/out_data/out_last  dump
//           done, err                   status
//  Rev    : 1.0  initial release
// ============================================================================
module conv_host_responder
    import conv_host_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          img_we,
    input  wire logic [AW-1:0] img_waddr,
    input  wire logic [DW-1:0] img_wdata,
    input  wire logic          start,
    conv_host_if.slave         eng,
    output logic               out_valid,
    input  wire logic          out_ready,
    output logic               out_bank,
    output logic [AW-1:0]      out_addr,
    output logic [DW-1:0]      out_data,
    output logic               out_last,
    output logic               done,
    output logic               err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int PTR_W = $clog2(DUMP_WORDS + 1);

    state_t             r_state, w_next;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_busy_q;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_out_valid, r_out_bank, r_out_last, r_err;
    logic [AW-1:0]      r_out_addr;
    logic [DW-1:0]      r_out_data;

    logic               w_fsm_err, w_wr_err, w_rd_err;
    logic               w_in_run, w_in_dump, w_img_load;
    logic               w_sel_l0, w_sel_l1, w_wr_l1_ok, w_rd_l1_ok;
    logic               w_l0_we, w_l1_we, w_ptr_l1;
    logic               w_dump_fin, w_dump_load;
    logic [AW-1:0]      w_l0_raddr;
    logic [L1_AW-1:0]   w_l1_raddr;
    logic [DW-1:0]      w_l0_rdata, w_l1_rdata;

    assign w_in_run   = (r_state == RUN);
    assign w_in_dump  = (r_state == DUMP);
    assign w_img_load = img_we && ((r_state == IDLE) || (r_state == DONE));

    assign w_sel_l0   = (eng.csel == CSEL_L0);
    assign w_sel_l1   = (eng.csel == CSEL_L1);
    assign w_wr_l1_ok = l1_addr_ok(eng.caddr_wr);
    assign w_rd_l1_ok = l1_addr_ok(eng.caddr_rd);

    assign w_l0_we    = eng.cwr && w_in_run && w_sel_l0;
    assign w_l1_we    = eng.cwr && w_in_run && w_sel_l1 && w_wr_l1_ok;
    assign w_wr_err   = eng.cwr && (!w_in_run || !(w_sel_l0 || (w_sel_l1 && w_wr_l1_ok)));
    assign w_rd_err   = eng.crd && !(w_sel_l0 || (w_sel_l1 && w_rd_l1_ok));

    // The engine is idle during DUMP, so the layer read ports are borrowed
    // by the dump pointer without any arbitration.
    assign w_ptr_l1   = (r_ptr >= PTR_W'(L0_DEPTH));
    assign w_l0_raddr = w_in_dump ? r_ptr[AW-1:0]    : eng.caddr_rd;
    assign w_l1_raddr = w_in_dump ? r_ptr[L1_AW-1:0] : eng.caddr_rd[L1_AW-1:0];

    // Dump output register: load when empty or when the held word is taken;
    // once the last word is out, its acceptance ends the dump instead.
    assign w_dump_fin  = w_in_dump && r_out_valid && out_ready && r_out_last;
    assign w_dump_load = w_in_dump && (!r_out_valid || out_ready) && !(r_out_valid && r_out_last);

    assign eng.cdata_rd = !eng.crd                ? '0 :
                          w_sel_l0                ? w_l0_rdata :
                          (w_sel_l1 && w_rd_l1_ok) ? w_l1_rdata : '0;

    // ready is decoded from state so an asynchronous reset drops it at once.
    assign eng.ready = (r_state == ARM);
    assign done      = (r_state == DONE);
    assign out_valid = r_out_valid;
    assign out_bank  = r_out_bank;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign err       = r_err;

    conv_bank_ram #(.DEPTH(L0_DEPTH), .ADDR_W(AW), .DATA_W(DW)) u_img_ram (
        .clk(clk), .we(w_img_load), .waddr(img_waddr), .wdata(img_wdata),
        .raddr(eng.iaddr), .rdata(eng.idata)
    );

    conv_bank_ram #(.DEPTH(L0_DEPTH), .ADDR_W(AW), .DATA_W(DW)) u_l0_ram (
        .clk(clk), .we(w_l0_we), .waddr(eng.caddr_wr), .wdata(eng.cdata_wr),
        .raddr(w_l0_raddr), .rdata(w_l0_rdata)
    );

    conv_bank_ram #(.DEPTH(L1_DEPTH), .ADDR_W(L1_AW), .DATA_W(DW)) u_l1_ram (
        .clk(clk), .we(w_l1_we), .waddr(eng.caddr_wr[L1_AW-1:0]), .wdata(eng.cdata_wr),
        .raddr(w_l1_raddr), .rdata(w_l1_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_fsm_err = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = ARM;
            ARM: begin
                if (eng.busy) begin
                    w_next = RUN;
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    w_next    = IDLE;
                    w_fsm_err = 1'b1;
                end
            end
            // RUN is only entered with busy high, so busy low here is the fall.
            RUN:  if (!eng.busy) w_next = DUMP;
            DUMP: begin
                if (w_dump_fin) w_next = DONE;
                if (eng.busy && !r_busy_q) w_fsm_err = 1'b1;
            end
            DONE: if (start) w_next = ARM;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_q    <= 1'b0;
            r_tmo_cnt   <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_bank  <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_busy_q  <= eng.busy;
            r_tmo_cnt <= (r_state == ARM) ? r_tmo_cnt + 1'b1 : '0;
            if (w_fsm_err || w_wr_err || w_rd_err) begin
                r_err <= 1'b1;
            end
            if (!w_in_dump) begin
                r_ptr       <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_dump_fin) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_dump_load) begin
                r_out_valid <= 1'b1;
                r_out_bank  <= w_ptr_l1;
                r_out_addr  <= w_ptr_l1 ? {{(AW-L1_AW){1'b0}}, r_ptr[L1_AW-1:0]} : r_ptr[AW-1:0];
                r_out_data  <= w_ptr_l1 ? w_l1_rdata : w_l0_rdata;
                r_out_last  <= (r_ptr == PTR_W'(DUMP_WORDS - 1));
                r_ptr       <= r_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_host_responder.sv
`default_nettype none
// ============================================================================
//  Module : tb_conv_host_responder
//  Brief  : Directed self-checking bench for conv_host_responder: image load
//           and serve, layer read/write, error paths, full dump with stalls,
//           reset mid-dump and the ARM timeout.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_conv_host_responder;
    import conv_host_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          img_we;
    logic [AW-1:0] img_waddr;
    logic [DW-1:0] img_wdata;
    logic          start;
    logic          out_valid, out_ready, out_bank, out_last, done, err;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    conv_host_if eif ();

    conv_host_responder #(.TIMEOUT_CYC(1024)) dut (
        .clk(clk), .reset(reset),
        .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
        .start(start), .eng(eif),
        .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic layer_wr(input logic [2:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        eif.cwr = 1'b1; eif.csel = sel; eif.caddr_wr = a; eif.cdata_wr = d;
        tick();
        eif.cwr = 1'b0;
    endtask

    task automatic layer_rd(input string tag, input logic [2:0] sel, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp);
        eif.crd = 1'b1; eif.csel = sel; eif.caddr_rd = a;
        #1;
        check(tag, eif.cdata_rd, exp);
        eif.crd = 1'b0;
    endtask

    initial begin
        int k, cyc, ea;
        logic pv, pr, known;
        logic [13:0] pword, eword;
        logic [DW-1:0] pdata, edata;

        reset = 1'b1; img_we = 1'b0; img_waddr = '0; img_wdata = '0; start = 1'b0;
        out_ready = 1'b0;
        eif.busy = 1'b0; eif.iaddr = '0; eif.cwr = 1'b0; eif.caddr_wr = '0; eif.cdata_wr = '0;
        eif.crd = 1'b0; eif.caddr_rd = '0; eif.csel = 3'b000;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_ready", eif.ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_misc", {out_bank, out_last, done, err}, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);

        // Image load img[i] = i
        for (int i = 0; i < L0_DEPTH; i++) begin
            img_we = 1'b1; img_waddr = AW'(i); img_wdata = DW'(i);
            tick();
        end
        img_we = 1'b0;

        // Start, busy after 5 cycles, ready falls one cycle later
        start = 1'b1; tick(); start = 1'b0;
        check("arm_ready", eif.ready, 1);
        repeat (4) tick();
        eif.busy = 1'b1;
        #1;
        check("ready_before_busy_sample", eif.ready, 1);
        tick();
        check("ready_after_busy", eif.ready, 0);

        for (int i = 0; i < L0_DEPTH; i++) begin
            eif.iaddr = AW'(i);
            #1;
            check("idata", eif.idata, i);
        end
        tick();

        // Layer write then read back; same-cycle write+read returns old data
        layer_wr(CSEL_L0, 12'd100, 20'h12345);
        layer_rd("l0_rd_100", CSEL_L0, 12'd100, 20'h12345);
        eif.cwr = 1'b1; eif.caddr_wr = 12'd100; eif.cdata_wr = 20'h54321;
        layer_rd("rd_during_wr_old", CSEL_L0, 12'd100, 20'h12345);
        tick();
        eif.cwr = 1'b0;
        layer_rd("rd_after_wr_new", CSEL_L0, 12'd100, 20'h54321);
        eif.caddr_rd = 12'd100;
        #1;
        check("crd_low_zero", eif.cdata_rd, 0);
        layer_wr(CSEL_L0, 12'd5,    20'h00555);
        layer_wr(CSEL_L0, 12'd4095, 20'h0FEDC);
        layer_wr(CSEL_L1, 12'd0,    20'h00777);
        layer_wr(CSEL_L1, 12'd5,    20'h11111);
        layer_wr(CSEL_L1, 12'd1023, 20'h0ABCD);
        layer_rd("l1_rd_1023", CSEL_L1, 12'd1023, 20'h0ABCD);
        check("err_clean", err, 0);

        // Error paths: memories must stay unchanged
        layer_wr(CSEL_L1, 12'd1024, 20'hFFFFF);
        #1;
        check("err_l1_oob_wr", err, 1);
        layer_wr(3'b010, 12'd5, 20'hFFFFF);
        layer_rd("rd_l1_oob_zero", CSEL_L1, 12'd1024, 20'h0);
        layer_rd("rd_bad_csel_zero", 3'b010, 12'd5, 20'h0);
        layer_rd("l1_0_unchanged", CSEL_L1, 12'd0, 20'h00777);
        layer_rd("l1_5_unchanged", CSEL_L1, 12'd5, 20'h11111);
        layer_rd("l0_5_unchanged", CSEL_L0, 12'd5, 20'h00555);
        check("err_sticky_run", err, 1);

        // Busy falls -> dump with out_ready toggling
        eif.busy = 1'b0;
        tick();
        k = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pword = '0; pdata = '0;
        while (k < DUMP_WORDS && cyc < 20000) begin
            out_ready = (cyc % 2 == 0);
            if (cyc == 0) check("dump_entry_no_valid", out_valid, 0);
            if (cyc == 1) check("dump_first_valid", out_valid, 1);
            if (pv && !pr) begin
                check("stall_valid", out_valid, 1);
                check("stall_word", {out_bank, out_addr, out_last}, pword);
                check("stall_data", out_data, pdata);
            end
            if (out_valid && out_ready) begin
                ea = (k < L0_DEPTH) ? k : k - L0_DEPTH;
                eword = {logic'(k >= L0_DEPTH), 12'(ea), logic'(k == DUMP_WORDS - 1)};
                check("dump_word", {out_bank, out_addr, out_last}, eword);
                known = 1'b1;
                case (k)
                    5:       edata = 20'h00555;
                    100:     edata = 20'h54321;
                    4095:    edata = 20'h0FEDC;
                    4096:    edata = 20'h00777;
                    4101:    edata = 20'h11111;
                    5119:    edata = 20'h0ABCD;
                    default: begin edata = '0; known = 1'b0; end
                endcase
                if (known) check("dump_data", out_data, edata);
                k++;
            end
            pv = out_valid; pr = out_ready;
            pword = {out_bank, out_addr, out_last}; pdata = out_data;
            cyc++;
            tick();
        end
        check("dump_count", k, DUMP_WORDS);
        check("done_after_dump", done, 1);
        check("valid_after_dump", out_valid, 0);
        check("err_sticky_done", err, 1);
        out_ready = 1'b0;

        // Reset asserted mid-dump
        start = 1'b1; tick(); start = 1'b0;
        check("rearm_from_done", eif.ready, 1);
        check("done_clears", done, 0);
        eif.busy = 1'b1; tick();
        eif.busy = 1'b0; tick();
        tick(); tick();
        check("mid_dump_valid", out_valid, 1);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_done_ready", {done, eif.ready}, 0);
        check("rst_async_err", err, 0);
        tick();
        reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("rearm_after_reset", eif.ready, 1);

        // ARM timeout without busy
        repeat (1000) tick();
        check("tmo_not_yet_ready", eif.ready, 1);
        check("tmo_not_yet_err", err, 0);
        repeat (30) tick();
        check("tmo_ready_low", eif.ready, 0);
        check("tmo_err", err, 1);
        check("tmo_idle_not_done", done, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("tmo_idle_restart", eif.ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
